// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
//   Shared constants and types for the VGA display back-end.
//   - Default 640x480@60 timing (pixels / lines) and the derived totals.
//   - Sync pulse start/end positions for the default timing.
//   - pixel_t (8-bit grayscale) and rgb_t (24-bit {R,G,B}).
//   - gray_to_rgb(): expands a gray byte into an equal-channel colour.
// ---------------------------------------------------------------------------
package display_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 800
    localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 525

    // Sync pulses cover [START, END).
    localparam int HS_START = VGA_H_ACTIVE + VGA_H_FP;   // 656
    localparam int HS_END   = HS_START + VGA_H_SYNC;     // 752
    localparam int VS_START = VGA_V_ACTIVE + VGA_V_FP;   // 490
    localparam int VS_END   = VS_START + VGA_V_SYNC;     // 492

    typedef logic [7:0]  pixel_t;
    typedef logic [23:0] rgb_t;

    function automatic rgb_t gray_to_rgb(input pixel_t p);
        return {p, p, p};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Pixel-tick divider plus horizontal/vertical position counters.
//   Ports:
//     clk    - block clock
//     rst    - asynchronous, active-low reset
//     tick   - one-clk pulse every CLK_DIV clks; pixel state moves only here
//     h, v   - current pixel position (h: 0..H_total-1, v: 0..V_total-1)
//     active - position lies inside the visible area
//     hs_n   - horizontal sync for this position, active-low
//     vs_n   - vertical sync for this position, active-low
// ---------------------------------------------------------------------------
module vga_timing
    import display_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           tick,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           active,
    output logic           hs_n,
    output logic           vs_n
);

    localparam int H_PERIOD   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_PERIOD   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_ON  = H_ACTIVE + H_FP;
    localparam int H_SYNC_OFF = H_SYNC_ON + H_SYNC;
    localparam int V_SYNC_ON  = V_ACTIVE + V_FP;
    localparam int V_SYNC_OFF = V_SYNC_ON + V_SYNC;
    localparam int DIV_W      = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking (<=) so every flop samples the
        // pre-edge value of its neighbours, independent of statement order.
        if (!rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (tick) begin
            div <= '0;
            if (h == H_W'(H_PERIOD - 1)) begin
                h <= '0;
                v <= (v == V_W'(V_PERIOD - 1)) ? '0 : v + V_W'(1);
            end else begin
                h <= h + H_W'(1);
            end
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Comparisons are done in int so boundary constants never truncate.
    assign active = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    assign hs_n   = !((int'(h) >= H_SYNC_ON) && (int'(h) < H_SYNC_OFF));
    assign vs_n   = !((int'(v) >= V_SYNC_ON) && (int'(v) < V_SYNC_OFF));

endmodule

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//   VGA display back-end: generates raster timing, reads 8-bit gray pixels
//   from the image memory and presents them as gray RGB with syncs.
//   Ports:
//     clk          - single clock
//     rst          - asynchronous, active-low reset
//     image_select - async switch: 0 = source image, 1 = interpolated image
//     mem_addr     - pixel read address (holds between reads)
//     mem_rd       - one-clk read strobe, only inside the image window
//     mem_data     - pixel byte, valid one clk after mem_rd
//     hsync, vsync - active-low syncs, aligned with RGB
//     RGB          - {R,G,B} colour, zero outside the image window
//     blank        - high outside the visible area
//     frame_start  - one-clk pulse when pixel (0,0) is issued
// ---------------------------------------------------------------------------
module vga_scanout
    import display_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADDR_W   = 17,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              image_select,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              hsync,
    output logic              vsync,
    output logic [23:0]       RGB,
    output logic              blank,
    output logic              frame_start
);

    localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int IW  = $clog2(IMG_W);
    localparam int IV  = $clog2(IMG_H);

    logic           tick;
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           active;
    logic           hs_n;
    logic           vs_n;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .h      (h),
        .v      (v),
        .active (active),
        .hs_n   (hs_n),
        .vs_n   (vs_n)
    );

    // image_select synchroniser; sel_sync[1] is the usable value.
    logic [1:0] sel_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_sync <= '0;
        end else begin
            sel_sync <= {sel_sync[0], image_select};
        end
    end

    logic              sel_frame;
    logic              sel_next;
    logic              at_origin;
    logic              in_img;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rd_addr;

    // The selection only changes at the origin pixel, so a whole frame
    // always comes from one image. The origin pixel itself already uses the
    // freshly latched selection.
    assign at_origin = tick && (h == '0) && (v == '0);
    assign sel_next  = at_origin ? sel_sync[1] : sel_frame;
    assign base      = sel_next ? ADDR_W'(DST_BASE) : ADDR_W'(SRC_BASE);
    assign in_img    = (int'(h) < IMG_W) && (int'(v) < IMG_H);
    assign rd_addr   = base + ADDR_W'({v[IV-1:0], h[IW-1:0]});

    // Stage-1 registers carried alongside the outstanding memory read.
    logic s1_active;
    logic s1_in_img;
    logic s1_hs_n;
    logic s1_vs_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_frame   <= 1'b0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            frame_start <= 1'b0;
            s1_active   <= 1'b0;
            s1_in_img   <= 1'b0;
            s1_hs_n     <= 1'b1;
            s1_vs_n     <= 1'b1;
            RGB         <= '0;
            blank       <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
        end else begin
            // Strobes are single-clk: cleared every clk, set only on a tick.
            mem_rd      <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                // Stage 1: issue the read for the current position.
                sel_frame   <= sel_next;
                frame_start <= at_origin;
                if (in_img) begin
                    mem_rd   <= 1'b1;
                    mem_addr <= rd_addr;
                end
                s1_active <= active;
                s1_in_img <= in_img;
                s1_hs_n   <= hs_n;
                s1_vs_n   <= vs_n;

                // Stage 2: previous pixel's data has been stable for
                // CLK_DIV-1 clks, so it is sampled together with its syncs.
                RGB   <= s1_in_img ? gray_to_rgb(mem_data) : '0;
                blank <= !s1_active;
                hsync <= s1_hs_n;
                vsync <= s1_vs_n;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//   Scoreboard bench for vga_scanout on a scaled-down raster (24x17 pixel
//   frame, 8x8 image, CLK_DIV=3) so several whole frames fit in a short run.
//   A reference model predicts, per pixel tick, the read request and the
//   displayed pixel from plain raster arithmetic and pushes timestamped
//   expectations into queues; a monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

    localparam int CLK_DIV  = 3;
    localparam int HA       = 16;
    localparam int HFP      = 2;
    localparam int HS       = 4;
    localparam int HBP      = 2;
    localparam int VA       = 12;
    localparam int VFP      = 1;
    localparam int VS       = 2;
    localparam int VBP      = 2;
    localparam int IMG_W    = 8;
    localparam int IMG_H    = 8;
    localparam int ADDR_W   = 8;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 128;

    localparam int HT         = HA + HFP + HS + HBP;   // 24
    localparam int VT         = VA + VFP + VS + VBP;   // 17
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;     // 1224
    localparam int MEM_SIZE   = 1 << ADDR_W;
    localparam int MAX_E      = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic              image_select;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data = 8'h00;
    logic              hsync;
    logic              vsync;
    logic [23:0]       RGB;
    logic              blank;
    logic              frame_start;

    always #5 clk = ~clk;

    vga_scanout #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .ADDR_W   (ADDR_W),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .image_select (image_select),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .hsync        (hsync),
        .vsync        (vsync),
        .RGB          (RGB),
        .blank        (blank),
        .frame_start  (frame_start)
    );

    // Image memory: contents fixed at time 0, 1-clk read latency.
    logic [7:0] mem [0:MEM_SIZE-1];
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    typedef struct {
        int                edge_n;
        logic [ADDR_W-1:0] addr;
    } rd_rec_t;

    typedef struct {
        int          edge_n;
        logic [23:0] rgb;
        logic        blank;
        logic        hs;
        logic        vs;
    } disp_rec_t;

    rd_rec_t   rd_q[$];
    disp_rec_t disp_q[$];
    int        fs_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int model_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_pixels(input int n);
        repeat (n * CLK_DIV) @(negedge clk);
    endtask

    // Reference model. Clk edges are numbered from 1 after reset release;
    // pixel tick k is processed on edge (k+1)*CLK_DIV and its raster position
    // follows from k by division. The image choice for a frame is the
    // select input seen two edges before that frame's origin edge.
    logic hist [1:MAX_E];

    initial begin : model
        int   k, ph, pv, addr, prev_addr;
        logic sel_m, cur_in, prev_in, prev_act, prev_hs, prev_vs;
        rd_rec_t   rr;
        disp_rec_t dr;
        sel_m = 1'b0; prev_in = 1'b0; prev_act = 1'b0;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_addr = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                model_edge = 0;
                rd_q.delete();
                disp_q.delete();
                fs_q.delete();
                sel_m = 1'b0; prev_in = 1'b0; prev_act = 1'b0;
                prev_hs = 1'b1; prev_vs = 1'b1; prev_addr = 0;
            end else begin
                model_edge++;
                if (model_edge <= MAX_E) hist[model_edge] = image_select;
                if (model_edge % CLK_DIV == 0) begin
                    k  = model_edge / CLK_DIV - 1;
                    ph = k % HT;
                    pv = (k / HT) % VT;
                    if (ph == 0 && pv == 0) begin
                        fs_q.push_back(model_edge);
                        sel_m = (model_edge >= 3 && model_edge <= MAX_E + 2) ? hist[model_edge - 2] : 1'b0;
                    end
                    cur_in = (ph < IMG_W) && (pv < IMG_H);
                    addr   = (sel_m ? DST_BASE : SRC_BASE) + pv * IMG_W + ph;
                    if (cur_in) begin
                        rr.edge_n = model_edge;
                        rr.addr   = ADDR_W'(addr);
                        rd_q.push_back(rr);
                    end
                    // Display outputs on this tick belong to the previous pixel.
                    dr.edge_n = model_edge;
                    dr.rgb    = prev_in ? {3{mem[prev_addr]}} : 24'h0;
                    dr.blank  = !prev_act;
                    dr.hs     = prev_hs;
                    dr.vs     = prev_vs;
                    disp_q.push_back(dr);
                    prev_in   = cur_in;
                    prev_addr = cur_in ? addr : prev_addr;
                    prev_act  = (ph < HA) && (pv < VA);
                    prev_hs   = !((ph >= HA + HFP) && (ph < HA + HFP + HS));
                    prev_vs   = !((pv >= VA + VFP) && (pv < VA + VFP + VS));
                end
            end
        end
    end

    // Monitor: compares every clk (and right after reset assertion).
    initial begin : monitor
        logic [ADDR_W-1:0] hold_addr;
        logic              exp_rd, exp_fs;
        rd_rec_t           rr;
        disp_rec_t         cur;
        hold_addr = '0;
        cur.edge_n = 0; cur.rgb = 24'h0; cur.blank = 1'b1; cur.hs = 1'b1; cur.vs = 1'b1;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (!rst) begin
                check("rst_hsync", hsync, 1'b1);
                check("rst_vsync", vsync, 1'b1);
                check("rst_RGB", RGB, 24'h0);
                check("rst_blank", blank, 1'b1);
                check("rst_mem_rd", mem_rd, 1'b0);
                check("rst_mem_addr", mem_addr, '0);
                check("rst_frame_start", frame_start, 1'b0);
                hold_addr = '0;
                cur.rgb = 24'h0; cur.blank = 1'b1; cur.hs = 1'b1; cur.vs = 1'b1;
            end else begin
                exp_rd = (rd_q.size() > 0) && (rd_q[0].edge_n == model_edge);
                check("mem_rd", mem_rd, exp_rd);
                if (exp_rd) begin
                    rr = rd_q.pop_front();
                    hold_addr = rr.addr;
                end
                check("mem_addr", mem_addr, hold_addr);
                exp_fs = (fs_q.size() > 0) && (fs_q[0] == model_edge);
                if (exp_fs) void'(fs_q.pop_front());
                check("frame_start", frame_start, exp_fs);
                if ((disp_q.size() > 0) && (disp_q[0].edge_n == model_edge)) cur = disp_q.pop_front();
                check("RGB", RGB, cur.rgb);
                check("blank", blank, cur.blank);
                check("hsync", hsync, cur.hs);
                check("vsync", vsync, cur.vs);
            end
        end
    end

    // Pulse-width and period measurements against the raster constants.
    initial begin : sync_meas
        int hs_run, vs_run, fs_gap;
        bit fs_seen;
        hs_run = 0; vs_run = 0; fs_gap = 0; fs_seen = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                hs_run = 0; vs_run = 0; fs_gap = 0; fs_seen = 1'b0;
            end else begin
                if (!hsync) hs_run++;
                else if (hs_run > 0) begin
                    check("hsync_width_clks", hs_run, HS * CLK_DIV);
                    hs_run = 0;
                end
                if (!vsync) vs_run++;
                else if (vs_run > 0) begin
                    check("vsync_width_clks", vs_run, VS * HT * CLK_DIV);
                    vs_run = 0;
                end
                fs_gap++;
                if (frame_start) begin
                    if (fs_seen) check("frame_period_clks", fs_gap, FRAME_CLKS);
                    fs_seen = 1'b1;
                    fs_gap  = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst = 1'b0;
        image_select = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        repeat (10) @(negedge clk);
        rst = 1'b1;

        // Switch to the interpolated image mid-frame; takes effect next frame.
        run_pixels(6 * HT + 10);
        image_select = 1'b1;
        run_pixels(2 * HT * VT);

        // Random select toggles at arbitrary clks.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(20, 400)) @(negedge clk);
            image_select = ~image_select;
        end

        // Reset at an arbitrary raster position, release with select high.
        rst = 1'b0;
        image_select = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b1;

        // Mid-line reset inside the active area, right of the image window.
        run_pixels(5 * HT + 12);
        rst = 1'b0;
        image_select = 1'($urandom);
        repeat ($urandom_range(2, 12)) @(negedge clk);
        rst = 1'b1;
        run_pixels(HT * VT + 40);

        repeat (4) @(negedge clk);
        check("queues_drained", rd_q.size() + disp_q.size() + fs_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
